forward_control_unit: RTL and testbench
=======================================

Name: forward_control_unit

Overview:
- Sequential forwarding-and-stall controller for the 5-stage pipeline. It is the resolving side of the load-use hazard interface.
- Tracks destination info of in-flight instructions in its own EXE/MEM/WB shadow registers.
- Drives the operand-mux selects for the EXE stage and raises the load-use stall toward IF/ID.
- Also keeps saturating stall/forward performance counters, readable by debug logic.

Parameters:
REG_ADDR_W, 5, register address width
CNT_W, 16, width of each performance counter

Ports:
clk  input  1  pipeline clock
rst  input  1  synchronous, active-high reset
id_valid  input  1  ID stage holds a real instruction
id_src1  input  REG_ADDR_W  ID first source register
id_src2  input  REG_ADDR_W  ID second source register
id_is_two_source  input  1  id_src2 is actually read
id_dst  input  REG_ADDR_W  ID destination register
id_wb_en  input  1  ID instruction writes the register file
id_mem_r_en  input  1  ID instruction is a load
flush  input  1  branch taken; the instruction leaving ID is killed
hazard_stall  output  1  load-use stall; freezes PC and IF/ID
fwd_sel_a  output  2  EXE operand A select: 00 regfile, 01 MEM ALU result, 10 WB value
fwd_sel_b  output  2  EXE operand B select, same encoding
exe_dst  output  REG_ADDR_W  destination held in the EXE shadow slot
stall_count  output  CNT_W  cycles with hazard_stall high
fwd_count  output  CNT_W  cycles with any fwd_sel nonzero

Behaviour:
- One clock; synchronous, active-high reset.
- Shadow slots, all registered:
  - EXE: {v, src1, src2, two_src, dst, wb_en, mem_r_en}
  - MEM: {v, dst, wb_en}
  - WB: {v, dst, wb_en}
- Reset: all slot fields 0. hazard_stall=0, fwd_sel_a/b=00, exe_dst=0, both counters 0. Reset mid-operation discards every in-flight entry the next edge.
- hazard_stall (combinational from ID inputs and EXE slot) is 1 only when all hold:
  - id_valid=1, EXE.v=1, EXE.mem_r_en=1, EXE.dst!=0
  - and either id_src1==EXE.dst, or (id_is_two_source=1 and id_src2==EXE.dst).
- Every rising edge, unless rst:
  - WB <= MEM
  - MEM <= {EXE.v, EXE.dst, EXE.wb_en}
  - EXE <= bubble (all zero) if hazard_stall=1, flush=1, or id_valid=0; otherwise EXE <= ID fields with v=1.
- Stall and flush together: bubble; stall_count still increments.
- Forward selects (combinational from slots; 00 whenever EXE.v=0):
  - Operand A: 01 if MEM.v and MEM.wb_en and MEM.dst!=0 and MEM.dst==EXE.src1; else 10 if the same holds for WB; else 00.
  - Operand B: same rule using EXE.src2, and only when EXE.two_src=1; otherwise 00.
  - MEM has priority over WB when both match.
  - Register 0 is never forwarded.
- exe_dst = EXE.dst.
- Counters: increment by 1 on each edge where the condition holds. Both saturate at all-ones; no wrap.
- Latency:
  - Stall asserts in the same cycle the dependent instruction sits in ID and lasts exactly one cycle per load.
  - Forward selects apply to the instruction currently in EXE.

Decomposition:
- Shared pipeline package holds:
  - localparams FWD_REGFILE=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10
  - REG_ADDR_W
  - a packed struct type for the EXE slot.
- One natural sub-module, fwd_select, instantiated twice (A and B): pure compare/priority logic taking one source address, a use flag and the MEM/WB slots.
- Counters stay inline.

Test Plan:
1. rst=1 for 2 cycles with random ID inputs -> all outputs 0; first cycle after release, fwd_sel_a/b=00 and stall_count=0.
2. ADD r1 then ADD r2,r1,r3 (two-source) back-to-back -> no stall; second instruction in EXE sees fwd_sel_a=01, fwd_sel_b=00; fwd_count=1.
3. LW r1 then SUB r4,r3,r1 -> hazard_stall=1 for exactly one cycle, bubble enters EXE; next cycle SUB in EXE sees fwd_sel_b=10, fwd_sel_a=00; stall_count=1.
4. ADD r5 (to MEM) and ADD r5 (to WB) both ahead of OR r6,r5 -> fwd_sel_a=01, confirming MEM priority.
5. LW r0 then ADD r2,r0,r0 -> no stall; fwd_sel_a/b=00.
6. flush=1 while LW r1 is in ID, then ADD r2,r1 -> no stall, no forward. Separately, force stall_count to all-ones via long load-use sequence -> it holds at all-ones.

Source files
------------

// File: rtl/forward_control_unit_pkg.sv
// Shared pipeline definitions for the forwarding/stall controller:
// operand-mux encodings and the shadow-slot layouts.
package forward_control_unit_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_MEM     = 2'b01;
    localparam logic [1:0] FWD_WB      = 2'b10;

    typedef struct packed {
        logic                  v;
        logic [REG_ADDR_W-1:0] src1;
        logic [REG_ADDR_W-1:0] src2;
        logic                  two_src;
        logic [REG_ADDR_W-1:0] dst;
        logic                  wb_en;
        logic                  mem_r_en;
    } exe_slot_t;

    // MEM and WB only need to know who they will write.
    typedef struct packed {
        logic                  v;
        logic [REG_ADDR_W-1:0] dst;
        logic                  wb_en;
    } wb_slot_t;

endpackage

// File: rtl/forward_control_unit_fwd_select.sv
// Operand-mux select for one EXE source: MEM result wins over WB value,
// and register 0 is never forwarded.
module fwd_select
    import forward_control_unit_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  src_used,
    input  wb_slot_t              mem_slot,
    input  wb_slot_t              wb_slot,
    output logic [1:0]            sel
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_slot.v && mem_slot.wb_en && (mem_slot.dst != '0) && (mem_slot.dst == src);
    assign wb_hit  = wb_slot.v  && wb_slot.wb_en  && (wb_slot.dst  != '0) && (wb_slot.dst  == src);

    always_comb begin
        sel = FWD_REGFILE;
        if (src_used) begin
            if (mem_hit)     sel = FWD_MEM;
            else if (wb_hit) sel = FWD_WB;
        end
    end

endmodule

// File: rtl/forward_control_unit.sv
// Forwarding and load-use stall controller for the 5-stage pipeline,
// with saturating stall/forward performance counters.
module forward_control_unit #(
    parameter int REG_ADDR_W = forward_control_unit_pkg::REG_ADDR_W,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_is_two_source,
    input  logic [REG_ADDR_W-1:0] id_dst,
    input  logic                  id_wb_en,
    input  logic                  id_mem_r_en,
    input  logic                  flush,
    output logic                  hazard_stall,
    output logic [1:0]            fwd_sel_a,
    output logic [1:0]            fwd_sel_b,
    output logic [REG_ADDR_W-1:0] exe_dst,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      fwd_count
);

    import forward_control_unit_pkg::*;

    exe_slot_t exe;
    wb_slot_t  mem;
    wb_slot_t  wb;

    assign hazard_stall = id_valid && exe.v && exe.mem_r_en && (exe.dst != '0) &&
                          ((id_src1 == exe.dst) || (id_is_two_source && (id_src2 == exe.dst)));

    assign exe_dst = exe.dst;

    always_ff @(posedge clk) begin
        if (rst) begin
            exe         <= '0;
            mem         <= '0;
            wb          <= '0;
            stall_count <= '0;
            fwd_count   <= '0;
        end else begin
            wb  <= mem;
            mem <= '{v: exe.v, dst: exe.dst, wb_en: exe.wb_en};
            // A stalled or killed instruction leaves a bubble behind it.
            if (hazard_stall || flush || !id_valid) begin
                exe <= '0;
            end else begin
                exe <= '{v: 1'b1, src1: id_src1, src2: id_src2, two_src: id_is_two_source,
                         dst: id_dst, wb_en: id_wb_en, mem_r_en: id_mem_r_en};
            end
            if (hazard_stall && (stall_count != '1))
                stall_count <= stall_count + CNT_W'(1);
            if (((fwd_sel_a != FWD_REGFILE) || (fwd_sel_b != FWD_REGFILE)) && (fwd_count != '1))
                fwd_count <= fwd_count + CNT_W'(1);
        end
    end

    fwd_select u_fwd_a (
        .src      (exe.src1),
        .src_used (exe.v),
        .mem_slot (mem),
        .wb_slot  (wb),
        .sel      (fwd_sel_a)
    );

    fwd_select u_fwd_b (
        .src      (exe.src2),
        .src_used (exe.v && exe.two_src),
        .mem_slot (mem),
        .wb_slot  (wb),
        .sel      (fwd_sel_b)
    );

endmodule

// File: tb/tb_forward_control_unit.sv
// Bench for forward_control_unit: directed hazard scenarios plus random
// traffic, all checked against an instruction-level pipeline model.
module tb_forward_control_unit;

    localparam int AW   = 5;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    bit             clk = 1'b0;
    logic           rst = 1'b1;
    logic           id_valid = 1'b0;
    logic [AW-1:0]  id_src1 = '0;
    logic [AW-1:0]  id_src2 = '0;
    logic           id_is_two_source = 1'b0;
    logic [AW-1:0]  id_dst = '0;
    logic           id_wb_en = 1'b0;
    logic           id_mem_r_en = 1'b0;
    logic           flush = 1'b0;
    logic           hazard_stall;
    logic [1:0]     fwd_sel_a;
    logic [1:0]     fwd_sel_b;
    logic [AW-1:0]  exe_dst;
    logic [CW-1:0]  stall_count;
    logic [CW-1:0]  fwd_count;

    forward_control_unit #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .id_valid         (id_valid),
        .id_src1          (id_src1),
        .id_src2          (id_src2),
        .id_is_two_source (id_is_two_source),
        .id_dst           (id_dst),
        .id_wb_en         (id_wb_en),
        .id_mem_r_en      (id_mem_r_en),
        .flush            (flush),
        .hazard_stall     (hazard_stall),
        .fwd_sel_a        (fwd_sel_a),
        .fwd_sel_b        (fwd_sel_b),
        .exe_dst          (exe_dst),
        .stall_count      (stall_count),
        .fwd_count        (fwd_count)
    );

    initial forever #5 clk = ~clk;

    // One in-flight instruction as the model sees it.
    typedef struct {
        bit v;
        int s1;
        int s2;
        bit two;
        int d;
        bit wb;
        bit ld;
    } ins_t;

    ins_t m_exe, m_mem, m_wb;
    int   m_sc, m_fc;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic       obs_stall;
    logic [1:0] obs_fa, obs_fb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic bit writes(ins_t s, int src);
        return s.v && s.wb && (s.d != 0) && (s.d == src);
    endfunction

    function automatic int fwd_of(int src, bit used);
        if (!m_exe.v || !used) return 0;
        if (writes(m_mem, src)) return 1;
        if (writes(m_wb, src))  return 2;
        return 0;
    endfunction

    task automatic step(input bit r, input bit v, input int s1, input int s2, input bit two,
                        input int d, input bit wb, input bit ld, input bit fl);
        bit   e_st;
        int   e_fa, e_fb;
        ins_t bubble;
        @(negedge clk);
        rst = r; id_valid = v; id_src1 = s1[AW-1:0]; id_src2 = s2[AW-1:0];
        id_is_two_source = two; id_dst = d[AW-1:0]; id_wb_en = wb; id_mem_r_en = ld; flush = fl;
        #1;
        e_st = v && m_exe.v && m_exe.ld && (m_exe.d != 0) &&
               ((s1 == m_exe.d) || (two && (s2 == m_exe.d)));
        e_fa = fwd_of(m_exe.s1, 1'b1);
        e_fb = fwd_of(m_exe.s2, m_exe.two);
        check("hazard_stall", 32'(hazard_stall), 32'(e_st));
        check("fwd_sel_a",    32'(fwd_sel_a),    e_fa);
        check("fwd_sel_b",    32'(fwd_sel_b),    e_fb);
        check("exe_dst",      32'(exe_dst),      m_exe.d);
        check("stall_count",  32'(stall_count),  m_sc);
        check("fwd_count",    32'(fwd_count),    m_fc);
        obs_stall = hazard_stall; obs_fa = fwd_sel_a; obs_fb = fwd_sel_b;
        bubble = '{default: 0};
        if (r) begin
            m_exe = bubble; m_mem = bubble; m_wb = bubble; m_sc = 0; m_fc = 0;
        end else begin
            if (e_st && m_sc < CMAX) m_sc++;
            if ((e_fa != 0 || e_fb != 0) && m_fc < CMAX) m_fc++;
            m_wb  = m_mem;
            m_mem = m_exe;
            if (e_st || fl || !v) m_exe = bubble;
            else m_exe = '{v: 1, s1: s1, s2: s2, two: two, d: d, wb: wb, ld: ld};
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++) begin
            step(1, $urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 1));
            if (i == 1) begin
                check("rst_stall", 32'(obs_stall), 0);
                check("rst_fwd_a", 32'(obs_fa), 0);
                check("rst_fwd_b", 32'(obs_fb), 0);
                check("rst_exe_dst", 32'(exe_dst), 0);
            end
        end
    endtask

    initial begin
        m_exe = '{default: 0}; m_mem = '{default: 0}; m_wb = '{default: 0};
        m_sc = 0; m_fc = 0;

        do_reset();
        idle();
        check("post_rst_fwd_a", 32'(obs_fa), 0);
        check("post_rst_stall_count", 32'(stall_count), 0);

        // ADD r1 ; ADD r2,r1,r3
        do_reset();
        step(0, 1, 2, 3, 1, 1, 1, 0, 0);
        step(0, 1, 1, 3, 1, 2, 1, 0, 0);
        check("t2_no_stall", 32'(obs_stall), 0);
        idle();
        check("t2_fwd_a", 32'(obs_fa), 1);
        check("t2_fwd_b", 32'(obs_fb), 0);
        idle();
        check("t2_fwd_count", 32'(fwd_count), 1);

        // LW r1 ; SUB r4,r3,r1 (ID held during stall)
        do_reset();
        step(0, 1, 2, 0, 0, 1, 1, 1, 0);
        step(0, 1, 3, 1, 1, 4, 1, 0, 0);
        check("t3_stall", 32'(obs_stall), 1);
        step(0, 1, 3, 1, 1, 4, 1, 0, 0);
        check("t3_stall_one_cycle", 32'(obs_stall), 0);
        idle();
        check("t3_fwd_b", 32'(obs_fb), 2);
        check("t3_fwd_a", 32'(obs_fa), 0);
        check("t3_stall_count", 32'(stall_count), 1);

        // ADD r5 ; ADD r5 ; OR r6,r5
        do_reset();
        step(0, 1, 1, 2, 1, 5, 1, 0, 0);
        step(0, 1, 3, 4, 1, 5, 1, 0, 0);
        step(0, 1, 5, 0, 0, 6, 1, 0, 0);
        idle();
        check("t4_mem_priority", 32'(obs_fa), 1);

        // LW r0 ; ADD r2,r0,r0
        do_reset();
        step(0, 1, 3, 0, 0, 0, 1, 1, 0);
        step(0, 1, 0, 0, 1, 2, 1, 0, 0);
        check("t5_no_stall", 32'(obs_stall), 0);
        idle();
        check("t5_fwd_a", 32'(obs_fa), 0);
        check("t5_fwd_b", 32'(obs_fb), 0);

        // flushed LW r1 ; ADD r2,r1
        do_reset();
        step(0, 1, 3, 0, 0, 1, 1, 1, 1);
        step(0, 1, 1, 0, 0, 2, 1, 0, 0);
        check("t6_no_stall", 32'(obs_stall), 0);
        idle();
        check("t6_no_fwd", 32'(obs_fa), 0);

        // long load-use chain saturates stall_count
        do_reset();
        for (int i = 0; i < 600; i++) step(0, 1, 1, 0, 0, 1, 1, 1, 0);
        idle();
        check("sat_stall_count", 32'(stall_count), CMAX);
        for (int i = 0; i < 20; i++) step(0, 1, 1, 0, 0, 1, 1, 1, 0);
        check("sat_stall_hold", 32'(stall_count), CMAX);

        // random traffic over a small register set to provoke hazards
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0,
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                 $urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 9) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
